// File: rtl/d_fetch_queue.sv
// Decode-side instruction fetch queue: DEPTH-entry FIFO of {instr, pc} with split MIPS-style head fields.
// Optional macro D_IMM_EXT_EN adds sign/zero/lui-extended immediate outputs.
module d_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       F_valid,
   input  logic [31:0]                F_instr,
   input  logic [PC_W-1:0]            F_pc,
   output logic                       F_ready,
   input  logic                       D_stall,
   input  logic                       flush,
   output logic                       D_valid,
   output logic [31:0]                D_instr,
   output logic [PC_W-1:0]            D_pc,
   output logic [5:0]                 D_opcode,
   output logic [4:0]                 D_rs,
   output logic [4:0]                 D_rt,
   output logic [4:0]                 D_rd,
   output logic [4:0]                 D_shamt,
   output logic [5:0]                 D_func,
   output logic [15:0]                D_imm16,
   output logic [25:0]                D_imm26,
`ifdef D_IMM_EXT_EN
   output logic [31:0]                D_imm32_sext,
   output logic [31:0]                D_imm32_zext,
   output logic [31:0]                D_imm32_lui,
`endif
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]      r_instr [DEPTH];
   logic [PC_W-1:0]  r_pc    [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic             w_push;
   logic             w_pop;
   logic [31:0]      w_head_instr;
   logic [PC_W-1:0]  w_head_pc;

   // No pass-through: a full queue refuses even if the head pops this cycle.
   assign F_ready = (r_count < CW'(DEPTH));
   assign D_valid = (r_count != '0);
   assign count   = r_count;

   assign w_push  = F_valid && F_ready && !flush;
   assign w_pop   = D_valid && !D_stall && !flush;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; stale entries are unreachable once count is 0.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_instr[r_wptr] <= F_instr;
         r_pc[r_wptr]    <= F_pc;
      end
   end

   // Head is gated by D_valid so an empty queue presents an all-zero nop.
   assign w_head_instr = D_valid ? r_instr[r_rptr] : '0;
   assign w_head_pc    = D_valid ? r_pc[r_rptr]    : '0;

   assign D_instr  = w_head_instr;
   assign D_pc     = w_head_pc;
   assign D_opcode = w_head_instr[31:26];
   assign D_rs     = w_head_instr[25:21];
   assign D_rt     = w_head_instr[20:16];
   assign D_rd     = w_head_instr[15:11];
   assign D_shamt  = w_head_instr[10:6];
   assign D_func   = w_head_instr[5:0];
   assign D_imm16  = w_head_instr[15:0];
   assign D_imm26  = w_head_instr[25:0];

`ifdef D_IMM_EXT_EN
   assign D_imm32_sext = {{16{w_head_instr[15]}}, w_head_instr[15:0]};
   assign D_imm32_zext = {16'h0000, w_head_instr[15:0]};
   assign D_imm32_lui  = {w_head_instr[15:0], 16'h0000};
`endif

endmodule
